// File: rtl/serial_vec_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_vec_pkg -- state encoding, default sizing, frame-length helper
// Rev 1.0
// ---------------------------------------------------------------------------
package serial_vec_pkg;

  localparam int DEF_WORD_W       = 16;
  localparam int DEF_MAX_FEATURES = 6;
  localparam int DEF_DEPTH        = 1024;
  localparam int DEF_ADDR_W       = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits per serial frame: feat feature words plus the target word.
  function automatic int unsigned frame_len(input logic [3:0] feat,
                                            input int unsigned word_w);
    return (32'(feat) + 32'd1) * word_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_vec_assembler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_vec_assembler -- LSB-first bit collector for one vector frame
// Rev 1.0
// ---------------------------------------------------------------------------
module serial_vec_assembler
  import serial_vec_pkg::*;
#(
  parameter int DATA_W = 112,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              bit_in,
  input  logic [CNT_W-1:0]  len,
  output logic              last_bit,
  output logic [DATA_W-1:0] vec
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] asm_q, asm_d;

  // vec already contains the bit being consumed this cycle, so the parent
  // can capture a complete vector on the final bit without waiting.
  always_comb begin
    vec = asm_q;
    for (int i = 0; i < DATA_W; i++) begin
      if (shift_en && (CNT_W'(i) == cnt_q)) begin
        vec[i] = bit_in;
      end
    end
    last_bit = shift_en && (cnt_q == (len - 1'b1));

    cnt_d = cnt_q;
    asm_d = asm_q;
    if (clear || last_bit) begin
      cnt_d = '0;
      asm_d = '0;
    end else if (shift_en) begin
      cnt_d = cnt_q + 1'b1;
      asm_d = vec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_vec_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_vec_loader -- deserialises num_dp feature/target vectors into writes
// Rev 1.0
// ---------------------------------------------------------------------------
module serial_vec_loader
  import serial_vec_pkg::*;
#(
  parameter int  WORD_W       = DEF_WORD_W,
  parameter int  MAX_FEATURES = DEF_MAX_FEATURES,
  parameter int  DEPTH        = DEF_DEPTH,
  parameter int  ADDR_W       = DEF_ADDR_W,
  localparam int DATA_W       = WORD_W * (MAX_FEATURES + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W:0]   num_dp,
  input  logic [3:0]        feat,
  input  logic              ser,
  input  logic              ser_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   num_q, num_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_en_q, wr_en_d;
  logic              err_q, err_d;

  logic [31:0]       feat_ext, num_ext;
  logic              params_ok, can_start, accept;
  logic              asm_shift, asm_last;
  logic [DATA_W-1:0] asm_vec;

  assign feat_ext  = 32'(feat);
  assign num_ext   = 32'(num_dp);
  assign params_ok = (feat_ext >= 32'd1) && (feat_ext <= 32'(MAX_FEATURES)) &&
                     (num_ext  >= 32'd1) && (num_ext  <= 32'(DEPTH));
  assign can_start = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign accept    = can_start && start && params_ok;
  assign asm_shift = (state_q == ST_LOAD) && ser_valid;

  serial_vec_assembler #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_asm (
    .clk      (CLK),
    .rst      (RST),
    .clear    (accept),
    .shift_en (asm_shift),
    .bit_in   (ser),
    .len      (len_q),
    .last_bit (asm_last),
    .vec      (asm_vec)
  );

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    len_d   = len_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_en_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d = ST_LOAD;
          num_d   = num_dp;
          len_d   = CNT_W'(frame_len(feat, WORD_W));
          idx_d   = '0;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      ST_LOAD: begin
        if (asm_last) begin
          wr_en_d = 1'b1;
          addr_d  = idx_q;
          data_d  = asm_vec;
          // Index stops at num_dp-1; the final strobe also ends the load.
          if (((ADDR_W+1)'(idx_q) + 1'b1) == num_q) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      err_q   <= err_d;
    end
  end

  assign wr_en = wr_en_q;
  assign addr  = addr_q;
  assign data  = data_q;
  assign err   = err_q;
  assign busy  = (state_q == ST_LOAD);
  assign done  = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: doc/serial_vec_loader.md
SERIAL_VEC_LOADER -- requirements
Module: serial_vec_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 16, bits per feature/target word.
REQ-002 SHALL have parameter MAX_FEATURES, default 6, maximum features per vector (target word excluded).
REQ-003 SHALL have parameter DEPTH, default 1024, maximum vectors per load.
REQ-004 SHALL have parameter ADDR_W, default 10, address width; requires 2**ADDR_W >= DEPTH.
REQ-005 SHALL derive DATA_W = WORD_W*(MAX_FEATURES+1) as a localparam, not overridable.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 Port: CLK  input  1  rising-edge clock for all state.
REQ-008 Port: RST  input  1  synchronous active-high reset.
REQ-009 Port: start  input  1  one-cycle request to begin a load.
REQ-010 Port: num_dp  input  ADDR_W+1  vectors to load; sampled on accepted start.
REQ-011 Port: feat  input  4  features per vector; sampled on accepted start.
REQ-012 Port: ser  input  1  serial data bit, LSB first.
REQ-013 Port: ser_valid  input  1  ser qualifier; one bit consumed per high cycle.
REQ-014 Port: wr_en  output  1  one-cycle write strobe per completed vector.
REQ-015 Port: addr  output  ADDR_W  index of the vector on data, valid with wr_en.
REQ-016 Port: data  output  DATA_W  assembled vector; word k at bits [k*WORD_W +: WORD_W].
REQ-017 Port: busy  output  1  high in LOAD.
REQ-018 Port: done  output  1  high in DONE.
REQ-019 Port: err  output  1  one-cycle pulse on a rejected start.

Function
REQ-020 SHALL implement states IDLE, LOAD, DONE.
REQ-021 IDLE/DONE + start: num_dp in 1..DEPTH and feat in 1..MAX_FEATURES -> LOAD, clear bit count, vector index and assembly register; otherwise pulse err next cycle, stay IDLE.
REQ-022 Frame length SHALL be F = (feat+1)*WORD_W bits, computed once at start in CNT width, no truncation.
REQ-023 In LOAD each ser_valid cycle SHALL write ser to assembly bit [bit count], then increment bit count.
REQ-024 ser_valid low SHALL stall: no bit consumed, state held.
REQ-025 Assembly bits at index >= F SHALL read 0.
REQ-026 Cycle consuming bit F-1: next cycle data = full vector including that bit, wr_en = 1 for one cycle, addr = vector index (0-based).
REQ-027 Same cycle: bit count SHALL wrap to 0 and assembly register clear, so no stale bits reach the next vector; a ser_valid bit in the wr_en cycle is the next vector's bit 0.
REQ-028 data and addr SHALL hold stable until the next wr_en pulse.
REQ-029 After vector num_dp-1 completes: LOAD -> DONE in the same transition as its wr_en; no extra bits consumed.
REQ-030 ser/ser_valid outside LOAD and start during LOAD SHALL be ignored.
REQ-031 done SHALL stay high until an accepted start (drops next cycle) or RST.
REQ-032 Vector index SHALL not exceed num_dp-1; addr never wraps within a load.

Reset
REQ-033 RST SHALL force IDLE and set wr_en, busy, done, err, addr, data and all counters to 0 next edge.
REQ-034 RST mid-LOAD SHALL discard the partial vector with no wr_en; RST overrides simultaneous start.

Structure
REQ-035 Package serial_vec_pkg SHALL hold the state enum, default WORD_W/MAX_FEATURES/DEPTH and a frame-length function.
REQ-036 Sub-module serial_vec_assembler SHALL hold bit counter and assembly register (ports: clear, shift-enable, bit, length, last-bit flag, vector); FSM, index, strobes stay in the top.

Verification
REQ-037 feat=2, num_dp=3, 48 bits/vector, ser_valid always high -> wr_en at cycles 49, 97, 145 after start; addr 0,1,2; done high after third strobe.
REQ-038 feat=1, word0=0xA5C3, word1=0x1234 LSB first, ser_valid toggling 50% -> data[31:0]=0x1234A5C3, data[DATA_W-1:32]=0, single wr_en.
REQ-039 feat=6, num_dp=1, all ones -> data all 1s (112 bits), next load feat=1 all zeros -> data fully 0, no stale ones.
REQ-040 start with feat=0, feat=7 or num_dp=0 -> err pulse, busy stays 0, no wr_en.
REQ-041 RST after 20 bits of vector 1 -> no wr_en, all outputs 0; next start with feat=1, num_dp=2 completes normally at addr 0,1.
REQ-042 start during LOAD and ser_valid in DONE -> ignored; outputs unchanged until next accepted start.
